pat_tx: RTL

PAT_TX -- requirements
Module: pat_tx

---
 rtl/pat_tx_pkg.sv | 14 +
 rtl/pat_tx_shreg.sv | 70 +++++++
 rtl/pat_tx.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pat_tx_pkg.sv
// Shared types and default parameters for the pattern transmitter.
package pat_tx_pkg;

  localparam int unsigned PAT_WIDTH_DEF = 16;
  localparam int unsigned PAT_GAP_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } pat_state_e;

endpackage : pat_tx_pkg

// File: rtl/pat_tx_shreg.sv
// Pattern shift register with bit counter. The pattern is left-aligned on
// load so the next serial bit is always the MSB, and an aligned copy is kept
// so a repeated pass can restart without reloading.
module pat_tx_shreg
  import pat_tx_pkg::*;
#(
  parameter int unsigned WIDTH = PAT_WIDTH_DEF
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         load_i,
  input  logic                         restart_i,
  input  logic                         shift_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic [$clog2(WIDTH+1)-1:0]   len_i,
  output logic                         msb_next_o,
  output logic                         last_o
);

  localparam int unsigned LW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] aligned;

  // Next-state for pattern copy, working shifter and remaining-bit counter.
  always_comb begin
    pat_d   = pat_q;
    sh_d    = sh_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    // Bits at index >= len fall off the top and are never transmitted.
    aligned = data_i << (LW'(WIDTH) - len_i);
    if (load_i) begin
      pat_d = aligned;
      sh_d  = aligned;
      len_d = len_i;
      cnt_d = len_i - LW'(1);
    end else if (restart_i) begin
      sh_d  = pat_q;
      cnt_d = len_q - LW'(1);
    end else if (shift_i) begin
      sh_d = sh_q << 1;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - LW'(1);
      end
    end
  end

  // Shift register state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= '0;
      sh_q  <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      sh_q  <= sh_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  assign msb_next_o = sh_d[WIDTH-1];
  assign last_o     = (cnt_q == '0);

endmodule : pat_tx_shreg

// File: rtl/pat_tx.sv
// Serial pattern transmitter: accepts a pattern, sends it MSB-first for
// load_rep+1 passes with optional idle gaps, then pulses done.
module pat_tx
  import pat_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = PAT_WIDTH_DEF,
  parameter int unsigned GAP_CYCLES = PAT_GAP_DEF
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [WIDTH-1:0]            load_data,
  input  logic [$clog2(WIDTH+1)-1:0]  load_len,
  input  logic [3:0]                  load_rep,
  input  logic                        abort,
  output logic                        A,
  output logic                        a_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned LW = $clog2(WIDTH + 1);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  pat_state_e    state_q, state_d;
  logic [3:0]    pass_q, pass_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          a_q, a_d;
  logic          a_valid_q, a_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_ready_q, load_ready_d;

  logic [LW-1:0] len_eff;
  logic          sr_load, sr_restart, sr_shift;
  logic          sr_msb_next, sr_last;

  // Effective length: 0 (and anything out of range) selects the full width.
  always_comb begin
    len_eff = load_len;
    if (load_len == '0 || load_len > LW'(WIDTH)) begin
      len_eff = LW'(WIDTH);
    end
  end

  pat_tx_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (sr_load),
    .restart_i  (sr_restart),
    .shift_i    (sr_shift),
    .data_i     (load_data),
    .len_i      (len_eff),
    .msb_next_o (sr_msb_next),
    .last_o     (sr_last)
  );

  // Next-state, counters, shifter controls and next output values.
  always_comb begin
    state_d    = state_q;
    pass_d     = pass_q;
    gap_d      = gap_q;
    sr_load    = 1'b0;
    sr_restart = 1'b0;
    sr_shift   = 1'b0;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = SHIFT;
          pass_d  = load_rep;
          sr_load = 1'b1;
        end
      end
      SHIFT: begin
        if (!sr_last) begin
          sr_shift = 1'b1;
        end else if (pass_q != 4'd0) begin
          pass_d = pass_q - 4'd1;
          if (GAP_CYCLES != 0) begin
            state_d = GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end else begin
            sr_restart = 1'b1;
          end
        end else begin
          state_d = DONE;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d    = SHIFT;
          sr_restart = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every transition outside IDLE.
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      sr_load    = 1'b0;
      sr_restart = 1'b0;
      sr_shift   = 1'b0;
    end

    a_valid_d    = (state_d == SHIFT);
    a_d          = a_valid_d & sr_msb_next;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    load_ready_d = (state_d == IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pass_q       <= 4'd0;
      gap_q        <= '0;
      a_q          <= 1'b0;
      a_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      gap_q        <= gap_d;
      a_q          <= a_d;
      a_valid_q    <= a_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign A          = a_q;
  assign a_valid    = a_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = load_ready_q;

endmodule : pat_tx
